// File: rtl/id_pkg.sv
// id_pkg: opcodes, execute commands, instruction field positions,
// FSM states and the decoder control bundle for the ID stage.
package id_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_ADDI = 4'd5,
    OP_LD   = 4'd6,
    OP_ST   = 4'd7,
    OP_BEZ  = 4'd8,
    OP_BNE  = 4'd9,
    OP_JMP  = 4'd10,
    OP_CMP  = 4'd11,
    OP_MOV  = 4'd12,
    OP_MUL  = 4'd13
  } opcode_e;

  typedef enum logic [3:0] {
    EXE_NOP = 4'd0,
    EXE_ADD = 4'd1,
    EXE_SUB = 4'd2,
    EXE_AND = 4'd3,
    EXE_OR  = 4'd4,
    EXE_MOV = 4'd5,
    EXE_MUL = 4'd6
  } exe_cmd_e;

  typedef enum logic {
    ST_IDLE,
    ST_MUL_WAIT
  } id_state_e;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_LSB  = 8;
  localparam int RS2_LSB = 4;
  localparam int IMM_LSB = 0;

  typedef struct packed {
    logic [3:0] cmd;
    logic       wb_en;
    logic       mem_r_en;
    logic       mem_w_en;
    logic       comp_en;
    logic       mov_en;
    logic       mul_en;
    logic       use_imm;
    logic       is_bez;
    logic       is_bne;
    logic       is_jmp;
  } id_ctrl_t;

endpackage

// File: rtl/id_stage_pipe_decoder.sv
// id_decoder: opcode to control bundle, purely combinational.
// Unused opcodes 14-15 fall through to the all-zero NOP bundle.
module id_decoder
  import id_pkg::*;
(
  input  logic [3:0] opcode,
  output id_ctrl_t   ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (1'b1)
      (opcode == OP_ADD): begin
        ctrl.cmd   = EXE_ADD;
        ctrl.wb_en = 1'b1;
      end
      (opcode == OP_SUB): begin
        ctrl.cmd   = EXE_SUB;
        ctrl.wb_en = 1'b1;
      end
      (opcode == OP_AND): begin
        ctrl.cmd   = EXE_AND;
        ctrl.wb_en = 1'b1;
      end
      (opcode == OP_OR): begin
        ctrl.cmd   = EXE_OR;
        ctrl.wb_en = 1'b1;
      end
      (opcode == OP_ADDI): begin
        ctrl.cmd     = EXE_ADD;
        ctrl.wb_en   = 1'b1;
        ctrl.use_imm = 1'b1;
      end
      (opcode == OP_LD): begin
        ctrl.cmd      = EXE_ADD;
        ctrl.wb_en    = 1'b1;
        ctrl.mem_r_en = 1'b1;
        ctrl.use_imm  = 1'b1;
      end
      (opcode == OP_ST): begin
        ctrl.cmd      = EXE_ADD;
        ctrl.mem_w_en = 1'b1;
        ctrl.use_imm  = 1'b1;
      end
      (opcode == OP_BEZ): begin
        ctrl.use_imm = 1'b1;
        ctrl.is_bez  = 1'b1;
      end
      (opcode == OP_BNE): begin
        ctrl.use_imm = 1'b1;
        ctrl.is_bne  = 1'b1;
      end
      (opcode == OP_JMP): begin
        ctrl.use_imm = 1'b1;
        ctrl.is_jmp  = 1'b1;
      end
      (opcode == OP_CMP): begin
        ctrl.cmd     = EXE_SUB;
        ctrl.wb_en   = 1'b1;
        ctrl.comp_en = 1'b1;
      end
      (opcode == OP_MOV): begin
        ctrl.cmd    = EXE_MOV;
        ctrl.wb_en  = 1'b1;
        ctrl.mov_en = 1'b1;
      end
      (opcode == OP_MUL): begin
        ctrl.cmd    = EXE_MUL;
        ctrl.wb_en  = 1'b1;
        ctrl.mul_en = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: decode, branch resolve and ID/EX register.
// ID_MUL_SEQ_EN enables multi-cycle MUL occupancy sequencing.
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int WORD_LEN     = 16,
  parameter int REG_ADDR_LEN = 4,
  parameter int IMM_LEN      = 8,
  parameter int COMP_DEST    = 9,
  parameter int MUL_CYCLES   = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [15:0]             instruction,
  input  logic [WORD_LEN-1:0]     reg1,
  input  logic [WORD_LEN-1:0]     reg2,
  input  logic                    hazard_detected,
  output logic [REG_ADDR_LEN-1:0] src1,
  output logic [REG_ADDR_LEN-1:0] src2,
  output logic                    br_taken,
  output logic                    ex_valid,
  output logic [3:0]              ex_cmd,
  output logic [WORD_LEN-1:0]     ex_val1,
  output logic [WORD_LEN-1:0]     ex_val2,
  output logic [WORD_LEN-1:0]     ex_reg2,
  output logic [REG_ADDR_LEN-1:0] ex_dest,
  output logic [REG_ADDR_LEN-1:0] ex_src1,
  output logic [REG_ADDR_LEN-1:0] ex_src2_forw,
  output logic                    ex_wb_en,
  output logic                    ex_mem_r_en,
  output logic                    ex_mem_w_en,
  output logic                    ex_comp_en,
  output logic                    ex_mov_en,
  output logic                    ex_mul_en
);

  id_ctrl_t                ctrl;
  logic [3:0]              opcode;
  logic [REG_ADDR_LEN-1:0] rd;
  logic [REG_ADDR_LEN-1:0] rs2;
  logic [REG_ADDR_LEN-1:0] dest_d;
  logic [REG_ADDR_LEN-1:0] src2f_d;
  logic [IMM_LEN-1:0]      imm;
  logic [WORD_LEN-1:0]     imm_ext;
  logic [WORD_LEN-1:0]     val2_d;
  logic                    accept;
  logic                    br_cond;

  assign opcode  = instruction[OPC_MSB:OPC_LSB];
  assign rd      = instruction[RD_LSB +: REG_ADDR_LEN];
  assign rs2     = instruction[RS2_LSB +: REG_ADDR_LEN];
  assign imm     = instruction[IMM_LSB +: IMM_LEN];
  assign imm_ext = {{(WORD_LEN-IMM_LEN){imm[IMM_LEN-1]}}, imm};

  id_decoder u_dec (
    .opcode (opcode),
    .ctrl   (ctrl)
  );

  assign src1   = rd;
  assign src2   = rs2;
  assign accept = in_valid & in_ready;

  assign br_cond = (ctrl.is_bez & (reg1 == '0))
                 | (ctrl.is_bne & (reg1 != reg2))
                 | ctrl.is_jmp;
  assign br_taken = accept & br_cond;

  assign val2_d  = ctrl.use_imm ? imm_ext : reg2;
  assign src2f_d = ctrl.use_imm ? '0 : rs2;
  assign dest_d  = ctrl.comp_en ? REG_ADDR_LEN'(COMP_DEST) : rd;

  // Anything not accepted lands in ID/EX as an all-zero bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_cmd       <= '0;
      ex_val1      <= '0;
      ex_val2      <= '0;
      ex_reg2      <= '0;
      ex_dest      <= '0;
      ex_src1      <= '0;
      ex_src2_forw <= '0;
      ex_wb_en     <= 1'b0;
      ex_mem_r_en  <= 1'b0;
      ex_mem_w_en  <= 1'b0;
      ex_comp_en   <= 1'b0;
      ex_mov_en    <= 1'b0;
      ex_mul_en    <= 1'b0;
    end else begin
      ex_valid     <= accept;
      ex_cmd       <= accept ? ctrl.cmd : '0;
      ex_val1      <= accept ? reg1 : '0;
      ex_val2      <= accept ? val2_d : '0;
      ex_reg2      <= accept ? reg2 : '0;
      ex_dest      <= accept ? dest_d : '0;
      ex_src1      <= accept ? rd : '0;
      ex_src2_forw <= accept ? src2f_d : '0;
      ex_wb_en     <= accept & ctrl.wb_en;
      ex_mem_r_en  <= accept & ctrl.mem_r_en;
      ex_mem_w_en  <= accept & ctrl.mem_w_en;
      ex_comp_en   <= accept & ctrl.comp_en;
      ex_mov_en    <= accept & ctrl.mov_en;
      ex_mul_en    <= accept & ctrl.mul_en;
    end
  end

`ifdef ID_MUL_SEQ_EN
  localparam int CNT_W = $clog2(MUL_CYCLES + 1);

  id_state_e        state;
  id_state_e        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Hazards only gate acceptance; the wait countdown keeps running.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      ST_IDLE: begin
        if (accept && ctrl.mul_en) begin
          state_nxt = ST_MUL_WAIT;
          cnt_nxt   = CNT_W'(MUL_CYCLES - 1);
        end
      end
      ST_MUL_WAIT: begin
        if (cnt == CNT_W'(1)) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign in_ready = ~hazard_detected & (state == ST_IDLE);
`else
  // MUL_CYCLES has no effect when MUL issues in a single cycle.
  if (MUL_CYCLES < 2) begin : g_mul_cycles_unused
  end

  assign in_ready = ~hazard_detected;
`endif

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: vector table plus scoreboard for id_stage_pipe,
// with MUL sequences that follow the ID_MUL_SEQ_EN build.
module tb_id_stage_pipe;
  import id_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] instruction;
  logic [15:0] reg1;
  logic [15:0] reg2;
  logic        hazard_detected;
  logic [3:0]  src1;
  logic [3:0]  src2;
  logic        br_taken;
  logic        ex_valid;
  logic [3:0]  ex_cmd;
  logic [15:0] ex_val1;
  logic [15:0] ex_val2;
  logic [15:0] ex_reg2;
  logic [3:0]  ex_dest;
  logic [3:0]  ex_src1;
  logic [3:0]  ex_src2_forw;
  logic        ex_wb_en;
  logic        ex_mem_r_en;
  logic        ex_mem_w_en;
  logic        ex_comp_en;
  logic        ex_mov_en;
  logic        ex_mul_en;

  id_stage_pipe #(
    .WORD_LEN     (16),
    .REG_ADDR_LEN (4),
    .IMM_LEN      (8),
    .COMP_DEST    (9),
    .MUL_CYCLES   (3)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .instruction     (instruction),
    .reg1            (reg1),
    .reg2            (reg2),
    .hazard_detected (hazard_detected),
    .src1            (src1),
    .src2            (src2),
    .br_taken        (br_taken),
    .ex_valid        (ex_valid),
    .ex_cmd          (ex_cmd),
    .ex_val1         (ex_val1),
    .ex_val2         (ex_val2),
    .ex_reg2         (ex_reg2),
    .ex_dest         (ex_dest),
    .ex_src1         (ex_src1),
    .ex_src2_forw    (ex_src2_forw),
    .ex_wb_en        (ex_wb_en),
    .ex_mem_r_en     (ex_mem_r_en),
    .ex_mem_w_en     (ex_mem_w_en),
    .ex_comp_en      (ex_comp_en),
    .ex_mov_en       (ex_mov_en),
    .ex_mul_en       (ex_mul_en)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        valid;
    logic [3:0]  cmd;
    logic [15:0] val1;
    logic [15:0] val2;
    logic [15:0] reg2;
    logic [3:0]  dest;
    logic [3:0]  src1;
    logic [3:0]  src2f;
    logic [5:0]  fl;
  } exp_t;

  typedef struct {
    logic [15:0] ins;
    logic [15:0] r1;
    logic [15:0] r2;
    logic        vld;
    logic        haz;
    logic        pulse;
    logic        rdy;
    logic        br;
    exp_t        e;
  } vec_t;

  localparam logic [5:0] F_0   = 6'b000000;
  localparam logic [5:0] F_WB  = 6'b100000;
  localparam logic [5:0] F_MR  = 6'b010000;
  localparam logic [5:0] F_MW  = 6'b001000;
  localparam logic [5:0] F_CMP = 6'b000100;
  localparam logic [5:0] F_MOV = 6'b000010;
  localparam logic [5:0] F_MUL = 6'b000001;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  vec_t tbl[$];
  vec_t mul_seq[$];

  function automatic vec_t mk(
    input logic [15:0] ins,
    input logic [15:0] r1,
    input logic [15:0] r2,
    input logic vld, input logic haz, input logic pulse,
    input logic rdy, input logic br, input logic exv,
    input logic [3:0] cmd,
    input logic [15:0] v2,
    input logic [3:0] dst,
    input logic [3:0] sf,
    input logic [5:0] fl
  );
    vec_t m;
    m.ins     = ins;
    m.r1      = r1;
    m.r2      = r2;
    m.vld     = vld;
    m.haz     = haz;
    m.pulse   = pulse;
    m.rdy     = rdy;
    m.br      = br;
    m.e.valid = exv;
    m.e.cmd   = cmd;
    m.e.val1  = exv ? r1 : 16'h0;
    m.e.val2  = v2;
    m.e.reg2  = exv ? r2 : 16'h0;
    m.e.dest  = dst;
    m.e.src1  = exv ? ins[11:8] : 4'h0;
    m.e.src2f = sf;
    m.e.fl    = fl;
    return m;
  endfunction

  function automatic vec_t bub(
    input logic [15:0] ins,
    input logic [15:0] r1,
    input logic [15:0] r2,
    input logic vld, input logic haz, input logic rdy
  );
    return mk(ins, r1, r2, vld, haz, 1'b0, rdy, 1'b0, 1'b0,
              EXE_NOP, 16'h0, 4'h0, 4'h0, F_0);
  endfunction

  task automatic chk(input int idx, input string nm,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL v%0d.%s actual=%0h required=%0h",
               idx, nm, act, exp);
    end
  endtask

  task automatic run(input vec_t t, input int idx);
    exp_t e;
    @(negedge clk);
    instruction     = t.ins;
    reg1            = t.r1;
    reg2            = t.r2;
    in_valid        = t.vld;
    hazard_detected = t.haz;
    if (t.pulse) begin
      #1 rst = 1'b1;
      #1;
      chk(idx, "rst_ex_valid", 32'(ex_valid), 32'(0));
      chk(idx, "rst_ex_val1", 32'(ex_val1), 32'(0));
      chk(idx, "rst_in_ready", 32'(in_ready), 32'(!t.haz));
      rst = 1'b0;
    end
    #1;
    chk(idx, "in_ready", 32'(in_ready), 32'(t.rdy));
    chk(idx, "br_taken", 32'(br_taken), 32'(t.br));
    chk(idx, "src1", 32'(src1), 32'(t.ins[11:8]));
    chk(idx, "src2", 32'(src2), 32'(t.ins[7:4]));
    sb.push_back(t.e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk(idx, "sb_empty", 32'(1), 32'(0));
    end else begin
      e = sb.pop_front();
      chk(idx, "ex_valid", 32'(ex_valid), 32'(e.valid));
      chk(idx, "ex_cmd", 32'(ex_cmd), 32'(e.cmd));
      chk(idx, "ex_val1", 32'(ex_val1), 32'(e.val1));
      chk(idx, "ex_val2", 32'(ex_val2), 32'(e.val2));
      chk(idx, "ex_reg2", 32'(ex_reg2), 32'(e.reg2));
      chk(idx, "ex_dest", 32'(ex_dest), 32'(e.dest));
      chk(idx, "ex_src1", 32'(ex_src1), 32'(e.src1));
      chk(idx, "ex_src2_forw", 32'(ex_src2_forw), 32'(e.src2f));
      chk(idx, "ex_flags",
          32'({ex_wb_en, ex_mem_r_en, ex_mem_w_en,
               ex_comp_en, ex_mov_en, ex_mul_en}),
          32'(e.fl));
    end
  endtask

  initial begin
    rst             = 1'b1;
    in_valid        = 1'b0;
    hazard_detected = 1'b0;
    instruction     = 16'h0;
    reg1            = 16'h0;
    reg2            = 16'h0;

    tbl.push_back(mk(16'h1312, 16'h0011, 16'h0022, 1, 0, 0, 1, 0, 1,
                     EXE_ADD, 16'h0022, 4'h3, 4'h1, F_WB));
    tbl.push_back(mk(16'h2645, 16'h0050, 16'h0010, 1, 0, 1, 1, 0, 1,
                     EXE_SUB, 16'h0010, 4'h6, 4'h4, F_WB));
    tbl.push_back(mk(16'h3789, 16'hF0F0, 16'h0FF0, 1, 0, 0, 1, 0, 1,
                     EXE_AND, 16'h0FF0, 4'h7, 4'h8, F_WB));
    tbl.push_back(mk(16'h4A1B, 16'h0001, 16'h1234, 1, 0, 0, 1, 0, 1,
                     EXE_OR, 16'h1234, 4'hA, 4'h1, F_WB));
    tbl.push_back(mk(16'h54F0, 16'h0007, 16'h0009, 1, 0, 0, 1, 0, 1,
                     EXE_ADD, 16'hFFF0, 4'h4, 4'h0, F_WB));
    tbl.push_back(mk(16'h5C7F, 16'h0001, 16'h0002, 1, 0, 0, 1, 0, 1,
                     EXE_ADD, 16'h007F, 4'hC, 4'h0, F_WB));
    tbl.push_back(mk(16'h9123, 16'h0005, 16'h0005, 1, 0, 0, 1, 0, 1,
                     EXE_NOP, 16'h0023, 4'h1, 4'h0, F_0));
    tbl.push_back(mk(16'h9123, 16'h0005, 16'h0006, 1, 0, 0, 1, 1, 1,
                     EXE_NOP, 16'h0023, 4'h1, 4'h0, F_0));
    tbl.push_back(mk(16'h8280, 16'h0000, 16'h0007, 1, 0, 0, 1, 1, 1,
                     EXE_NOP, 16'hFF80, 4'h2, 4'h0, F_0));
    tbl.push_back(mk(16'h8280, 16'h0003, 16'h0007, 1, 0, 0, 1, 0, 1,
                     EXE_NOP, 16'hFF80, 4'h2, 4'h0, F_0));
    tbl.push_back(mk(16'hA0FE, 16'h0001, 16'h0002, 1, 0, 0, 1, 1, 1,
                     EXE_NOP, 16'hFFFE, 4'h0, 4'h0, F_0));
    tbl.push_back(bub(16'h6A05, 16'h0100, 16'h0000, 1, 1, 0));
    tbl.push_back(mk(16'h6A05, 16'h0100, 16'h0000, 1, 0, 0, 1, 0, 1,
                     EXE_ADD, 16'h0005, 4'hA, 4'h0, F_WB | F_MR));
    tbl.push_back(mk(16'h7B81, 16'h0200, 16'hBEEF, 1, 0, 0, 1, 0, 1,
                     EXE_ADD, 16'hFF81, 4'hB, 4'h0, F_MW));
    tbl.push_back(mk(16'hB450, 16'h0004, 16'h0005, 1, 0, 0, 1, 0, 1,
                     EXE_SUB, 16'h0005, 4'h9, 4'h5, F_WB | F_CMP));
    tbl.push_back(mk(16'hC370, 16'h0000, 16'hABCD, 1, 0, 0, 1, 0, 1,
                     EXE_MOV, 16'hABCD, 4'h3, 4'h7, F_WB | F_MOV));
    tbl.push_back(mk(16'h0123, 16'h0001, 16'h0002, 1, 0, 0, 1, 0, 1,
                     EXE_NOP, 16'h0002, 4'h1, 4'h2, F_0));
    tbl.push_back(mk(16'hF456, 16'h0001, 16'h0002, 1, 0, 0, 1, 0, 1,
                     EXE_NOP, 16'h0002, 4'h4, 4'h5, F_0));
    tbl.push_back(bub(16'h1312, 16'h0011, 16'h0022, 0, 0, 1));
    tbl.push_back(bub(16'h9123, 16'h0001, 16'h0002, 0, 0, 1));
    tbl.push_back(bub(16'hA0FE, 16'h0001, 16'h0002, 1, 1, 0));
    tbl.push_back(bub(16'h1312, 16'h0011, 16'h0022, 0, 1, 0));

`ifdef ID_MUL_SEQ_EN
    mul_seq.push_back(bub(16'hD312, 16'h0003, 16'h0004, 1, 1, 0));
    mul_seq.push_back(mk(16'hD312, 16'h0003, 16'h0004, 1, 0, 0, 1, 0, 1,
                         EXE_MUL, 16'h0004, 4'h3, 4'h1, F_WB | F_MUL));
    mul_seq.push_back(bub(16'h1545, 16'h0001, 16'h0001, 1, 0, 0));
    mul_seq.push_back(bub(16'h1545, 16'h0001, 16'h0001, 1, 1, 0));
    mul_seq.push_back(mk(16'h1545, 16'h0001, 16'h0001, 1, 0, 0, 1, 0, 1,
                         EXE_ADD, 16'h0001, 4'h5, 4'h4, F_WB));
    mul_seq.push_back(mk(16'hD312, 16'h0003, 16'h0004, 1, 0, 0, 1, 0, 1,
                         EXE_MUL, 16'h0004, 4'h3, 4'h1, F_WB | F_MUL));
    mul_seq.push_back(bub(16'h1545, 16'h0001, 16'h0001, 1, 0, 0));
    mul_seq.push_back(mk(16'h1545, 16'h0001, 16'h0001, 1, 0, 1, 1, 0, 1,
                         EXE_ADD, 16'h0001, 4'h5, 4'h4, F_WB));
    mul_seq.push_back(mk(16'h1545, 16'h0001, 16'h0001, 1, 0, 0, 1, 0, 1,
                         EXE_ADD, 16'h0001, 4'h5, 4'h4, F_WB));
`else
    mul_seq.push_back(bub(16'hD312, 16'h0003, 16'h0004, 1, 1, 0));
    mul_seq.push_back(mk(16'hD312, 16'h0003, 16'h0004, 1, 0, 0, 1, 0, 1,
                         EXE_MUL, 16'h0004, 4'h3, 4'h1, F_WB | F_MUL));
    mul_seq.push_back(mk(16'h1545, 16'h0001, 16'h0001, 1, 0, 0, 1, 0, 1,
                         EXE_ADD, 16'h0001, 4'h5, 4'h4, F_WB));
    mul_seq.push_back(mk(16'hD312, 16'h0003, 16'h0004, 1, 0, 0, 1, 0, 1,
                         EXE_MUL, 16'h0004, 4'h3, 4'h1, F_WB | F_MUL));
    mul_seq.push_back(mk(16'h1545, 16'h0001, 16'h0001, 1, 0, 1, 1, 0, 1,
                         EXE_ADD, 16'h0001, 4'h5, 4'h4, F_WB));
`endif

    #1;
    chk(-1, "reset_ex_valid", 32'(ex_valid), 32'(0));
    chk(-1, "reset_ex_flags",
        32'({ex_wb_en, ex_mem_r_en, ex_mem_w_en,
             ex_comp_en, ex_mov_en, ex_mul_en}), 32'(0));
    chk(-1, "reset_ex_val2", 32'(ex_val2), 32'(0));
    chk(-1, "reset_in_ready", 32'(in_ready), 32'(1));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      run(tbl[i], i);
    end
    for (int i = 0; i < mul_seq.size(); i++) begin
      run(mul_seq[i], 100 + i);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
